// File: rtl/dda_move_splitter.sv
// Splits signed relative moves into rate-limited chunks and streams them into the
// DDA generator's chunk buffer, throttled by its full flag; abort flushes the buffer.
module dda_move_splitter #(
    parameter int WR_HIGH   = 2,
    parameter int WR_GAP    = 2,
    parameter int LS_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_steps,
    input  logic [6:0]  cmd_rate,
    input  logic        abort,
    input  logic        flag_full,
    output logic        wr,
    output logic [7:0]  nx,
    output logic        ls,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic [15:0] remaining
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_WRITE,
        S_GAP,
        S_FLUSH
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        dir_q, dir_d;
    logic [6:0]  rate_q, rate_d;
    logic [15:0] remaining_q, remaining_d;
    logic [7:0]  nx_q, nx_d;
    logic        done_q, done_d;
    logic        aborted_q, aborted_d;

    logic [15:0] cmd_mag;
    logic [6:0]  chunk;

    // Two's-complement negate; -32768 maps onto 0x8000, which is its magnitude.
    assign cmd_mag   = cmd_steps[15] ? (~cmd_steps + 16'd1) : cmd_steps;
    assign chunk     = ({9'd0, rate_q} < remaining_q) ? rate_q : remaining_q[6:0];
    assign cmd_ready = (state_q == S_IDLE) & ~abort & rst_n;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        rate_d      = rate_q;
        remaining_d = remaining_q;
        nx_d        = nx_q;
        done_d      = 1'b0;
        aborted_d   = 1'b0;

        if (abort && state_q != S_FLUSH) begin
            state_d     = S_FLUSH;
            cnt_d       = 8'd0;
            remaining_d = 16'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        dir_d       = cmd_steps[15];
                        remaining_d = cmd_mag;
                        rate_d      = (cmd_rate == 7'd0) ? 7'd1 : cmd_rate;
                        if (cmd_mag == 16'd0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (!flag_full) begin
                        nx_d    = {dir_q, chunk};
                        cnt_d   = 8'd0;
                        state_d = S_WRITE;
                    end
                end
                S_WRITE: begin
                    // The chunk only counts as written once the full strobe completes.
                    if (cnt_q == 8'(WR_HIGH - 1)) begin
                        remaining_d = remaining_q - {9'd0, nx_q[6:0]};
                        cnt_d       = 8'd0;
                        state_d     = S_GAP;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                S_GAP: begin
                    if (cnt_q == 8'(WR_GAP - 1)) begin
                        cnt_d = 8'd0;
                        if (remaining_q == 16'd0) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_CHECK;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                S_FLUSH: begin
                    // LS high for LS_CYCLES, then one low cycle before leaving.
                    if (cnt_q == 8'(LS_CYCLES)) begin
                        cnt_d = 8'd0;
                        if (!abort) begin
                            state_d   = S_IDLE;
                            aborted_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            dir_q       <= 1'b0;
            rate_q      <= 7'd1;
            remaining_q <= 16'd0;
            nx_q        <= 8'd0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            rate_q      <= rate_d;
            remaining_q <= remaining_d;
            nx_q        <= nx_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
        end
    end

    assign wr        = (state_q == S_WRITE);
    assign ls        = (state_q == S_FLUSH) && (cnt_q < 8'(LS_CYCLES));
    assign busy      = (state_q != S_IDLE);
    assign nx        = nx_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign remaining = remaining_q;

endmodule

// File: tb/tb_dda_move_splitter.sv
// Bench for dda_move_splitter: a move-level reference model fills an event queue and
// an independent monitor checks every write, done and aborted event against it.
module tb_dda_move_splitter;

    localparam int WR_HIGH   = 2;
    localparam int WR_GAP    = 2;
    localparam int LS_CYCLES = 2;

    localparam int EV_WR   = 0;
    localparam int EV_DONE = 1;
    localparam int EV_ABT  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_steps;
    logic [6:0]  cmd_rate;
    logic        abort;
    logic        flag_full;
    logic        wr;
    logic [7:0]  nx;
    logic        ls;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [15:0] remaining;

    typedef struct {
        int          kind;
        logic [7:0]  nx;
        logic [15:0] rem;
    } ev_t;

    ev_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    bit  rand_ff = 1'b0;
    logic       mon_wr_prev = 1'b0;
    logic [7:0] mon_nx_hold = 8'd0;

    dda_move_splitter #(
        .WR_HIGH  (WR_HIGH),
        .WR_GAP   (WR_GAP),
        .LS_CYCLES(LS_CYCLES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_steps(cmd_steps),
        .cmd_rate (cmd_rate),
        .abort    (abort),
        .flag_full(flag_full),
        .wr       (wr),
        .nx       (nx),
        .ls       (ls),
        .busy     (busy),
        .done     (done),
        .aborted  (aborted),
        .remaining(remaining)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a move of |steps| split greedily into chunks of at most max(rate,1).
    task automatic push_move(input int steps, input int rate, input int max_writes, input int end_kind);
        int  mag;
        int  r;
        int  c;
        int  n;
        bit  neg;
        ev_t e;
        neg = (steps < 0);
        mag = neg ? -steps : steps;
        r   = (rate == 0) ? 1 : rate;
        n   = 0;
        while (mag > 0 && n < max_writes) begin
            c      = (mag < r) ? mag : r;
            e.kind = EV_WR;
            e.nx   = 8'((neg ? 128 : 0) + c);
            e.rem  = 16'(mag);
            exp_q.push_back(e);
            mag = mag - c;
            n++;
        end
        if (end_kind >= 0) begin
            e.kind = end_kind;
            e.nx   = 8'd0;
            e.rem  = 16'd0;
            exp_q.push_back(e);
        end
    endtask

    task automatic pop_event(input int kind, output ev_t e, output bit ok);
        if (exp_q.size() == 0) begin
            chk("event_kind_unexpected", 32'(kind), 32'hFFFF_FFFF);
            ok = 1'b0;
            e.kind = -1;
            e.nx   = 8'd0;
            e.rem  = 16'd0;
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", 32'(kind), 32'(e.kind));
            ok = (kind == e.kind);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard queue.
    initial begin
        ev_t e;
        bit  ok;
        forever begin
            @(negedge clk);
            if (wr && !mon_wr_prev) begin
                pop_event(EV_WR, e, ok);
                if (ok) begin
                    chk("write_nx", 32'(nx), 32'(e.nx));
                    chk("write_remaining", 32'(remaining), 32'(e.rem));
                end
                mon_nx_hold = nx;
            end else if (wr) begin
                chk("nx_stable", 32'(nx), 32'(mon_nx_hold));
            end
            if (done) begin
                pop_event(EV_DONE, e, ok);
                chk("done_remaining", 32'(remaining), 32'd0);
                chk("done_busy", 32'(busy), 32'd0);
            end
            if (aborted) begin
                pop_event(EV_ABT, e, ok);
                chk("aborted_remaining", 32'(remaining), 32'd0);
            end
            if (wr && ls) chk("wr_ls_overlap", 32'(ls), 32'd0);
            mon_wr_prev = wr;
        end
    end

    task automatic do_cmd(input int steps, input int rate);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_steps = 16'(steps);
        cmd_rate  = 7'(rate);
        #1;
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int ls_seen);
        bit finished;
        finished = 1'b0;
        ls_seen  = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (ls) ls_seen++;
            if (exp_q.size() == 0 && !busy) begin
                finished = 1'b1;
                break;
            end
            if (rand_ff) flag_full = ($urandom_range(0, 3) == 0);
        end
        flag_full = 1'b0;
        if (!finished) begin
            chk("move_timeout_queue_left", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic wait_wr_rises(input int n);
        int   seen;
        logic prev;
        seen = 0;
        prev = wr;
        for (int i = 0; i < 500 && seen < n; i++) begin
            @(negedge clk);
            if (wr && !prev) seen++;
            prev = wr;
        end
        if (seen < n) chk("wr_rise_timeout", 32'(seen), 32'(n));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr"}, 32'(wr), 32'd0);
        chk({tag, "_ls"}, 32'(ls), 32'd0);
        chk({tag, "_nx"}, 32'(nx), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_aborted"}, 32'(aborted), 32'd0);
        chk({tag, "_remaining"}, 32'(remaining), 32'd0);
    endtask

    initial begin
        int ls_seen;
        int steps;
        int rate;
        bit saw_wr;
        bit saw_idle;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_steps = 16'd0;
        cmd_rate  = 7'd0;
        abort     = 1'b0;
        flag_full = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
        rst_n = 1'b1;

        // Positive move with first-write latency.
        push_move(300, 100, 1 << 30, EV_DONE);
        do_cmd(300, 100);
        @(negedge clk);
        chk("pos_check_busy", 32'(busy), 32'd1);
        chk("pos_check_wr", 32'(wr), 32'd0);
        @(negedge clk);
        chk("pos_first_wr", 32'(wr), 32'd1);
        chk("pos_first_nx", 32'(nx), 32'h64);
        wait_idle(1000, ls_seen);
        chk("pos_ls_quiet", 32'(ls_seen), 32'd0);
        $display("[TB] move 300 rate 100 complete");

        // Negative move with remainder.
        push_move(-250, 100, 1 << 30, EV_DONE);
        do_cmd(-250, 100);
        wait_idle(1000, ls_seen);
        chk("neg_ls_quiet", 32'(ls_seen), 32'd0);
        $display("[TB] move -250 rate 100 complete");

        // Backpressure after the first write.
        push_move(500, 50, 1 << 30, EV_DONE);
        do_cmd(500, 50);
        wait_wr_rises(1);
        flag_full = 1'b1;
        repeat (WR_HIGH + WR_GAP) @(negedge clk);
        saw_wr   = 1'b0;
        saw_idle = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wr) saw_wr = 1'b1;
            if (!busy) saw_idle = 1'b1;
        end
        chk("bp_wr_held_low", 32'(saw_wr), 32'd0);
        chk("bp_busy_dropped", 32'(saw_idle), 32'd0);
        flag_full = 1'b0;
        @(negedge clk);
        chk("bp_resume_wr", 32'(wr), 32'd1);
        wait_idle(1000, ls_seen);
        $display("[TB] move 500 rate 50 with backpressure complete");

        // Abort during the second chunk's write.
        push_move(500, 100, 2, EV_ABT);
        do_cmd(500, 100);
        wait_wr_rises(2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_wr_drop", 32'(wr), 32'd0);
        chk("abort_ls_1", 32'(ls), 32'd1);
        chk("abort_remaining", 32'(remaining), 32'd0);
        @(negedge clk);
        chk("abort_ls_2", 32'(ls), 32'd1);
        @(negedge clk);
        chk("abort_ls_low", 32'(ls), 32'd0);
        chk("abort_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("abort_pulse", 32'(aborted), 32'd1);
        chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        wait_idle(100, ls_seen);
        $display("[TB] abort sequence complete");

        // Zero-step command.
        push_move(0, 5, 1 << 30, EV_DONE);
        do_cmd(0, 5);
        @(negedge clk);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_wr", 32'(wr), 32'd0);
        wait_idle(100, ls_seen);
        $display("[TB] move 0 complete");

        // Most negative move at maximum rate.
        push_move(-32768, 127, 1 << 30, EV_DONE);
        do_cmd(-32768, 127);
        wait_idle(3000, ls_seen);
        $display("[TB] move -32768 rate 127 complete");

        // Rate 0 treated as 1.
        push_move(3, 0, 1 << 30, EV_DONE);
        do_cmd(3, 0);
        wait_idle(200, ls_seen);
        $display("[TB] move 3 rate 0 complete");

        // Reset during the first write.
        push_move(300, 100, 1, -1);
        do_cmd(300, 100);
        wait_wr_rises(1);
        rst_n = 1'b0;
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        chk_all_zero("midrst");
        rst_n = 1'b1;
        chk("midrst_queue", 32'(exp_q.size()), 32'd0);
        push_move(250, 100, 1 << 30, EV_DONE);
        do_cmd(250, 100);
        wait_idle(1000, ls_seen);
        $display("[TB] reset mid-write and recovery complete");

        // Randomized moves with a randomly toggling full flag.
        for (int k = 0; k < 15; k++) begin
            steps = int'($urandom_range(0, 600)) - 300;
            if ($urandom_range(0, 7) == 0) steps = 0;
            rate = int'($urandom_range(8, 127));
            if (k == 3) rate = 0;
            push_move(steps, rate, 1 << 30, EV_DONE);
            rand_ff = 1'b1;
            do_cmd(steps, rate);
            wait_idle(8000, ls_seen);
            rand_ff = 1'b0;
            $display("[TB] random move %0d rate %0d complete", steps, rate);
        end

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
